// File: rtl/pwm_ramp_controller_pkg.sv
// Shared definitions for the PWM ramp controller: FSM encoding and default widths.
package pwm_ramp_controller_pkg;

  localparam int unsigned DEF_R          = 32'd8;
  localparam int unsigned DEF_TIMER_BITS = 32'd16;
  localparam int unsigned DEF_HOLD_BITS  = 32'd8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // The ramp sequencer is busy in every state except IDLE.
  function automatic logic is_busy(input state_e st);
    return (st != ST_IDLE);
  endfunction

endpackage

// File: rtl/pwm_ramp_controller_timer.sv
// Free-running prescaler: counts 0..FINAL_VALUE and pulses done on the terminal count.
module timer #(
  parameter int unsigned BITS = 32'd4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [BITS-1:0] FINAL_VALUE,
  output logic            done
);

  localparam logic [BITS-1:0] CNT_ONE = {{(BITS-1){1'b0}}, 1'b1};

  logic [BITS-1:0] cnt_q;
  logic [BITS-1:0] cnt_d;

  // done is the terminal-count decode; the wrap to zero happens on the same edge.
  assign done = (cnt_q == FINAL_VALUE);

  // Next count: wrap on terminal count, otherwise advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      if (done) begin
        cnt_d = {BITS{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= {BITS{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_ramp_controller.sv
// Single-channel PWM with a duty ramp sequencer stepping duty by one toward a
// target every (hold+1) PWM periods, with a start/busy/done handshake.
module pwm_ramp_controller
  import pwm_ramp_controller_pkg::*;
#(
  parameter int unsigned R          = DEF_R,
  parameter int unsigned TIMER_BITS = DEF_TIMER_BITS,
  parameter int unsigned HOLD_BITS  = DEF_HOLD_BITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [R-1:0]          target,
  input  logic [HOLD_BITS-1:0]  hold,
  input  logic [TIMER_BITS-1:0] prescale,
  output logic [R-1:0]          duty,
  output logic                  pwm_out,
  output logic                  busy,
  output logic                  done
);

  localparam logic [R-1:0]         R_ONE    = {{(R-1){1'b0}}, 1'b1};
  localparam logic [R-1:0]         CNT_MAX  = {R{1'b1}};
  localparam logic [HOLD_BITS-1:0] HOLD_ONE = {{(HOLD_BITS-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [R-1:0]          duty_q, duty_d;
  logic [R-1:0]          target_q, target_d;
  logic [HOLD_BITS-1:0]  hold_q, hold_d;
  logic [HOLD_BITS-1:0]  hold_cnt_q, hold_cnt_d;
  logic [TIMER_BITS-1:0] pend_pre_q, pend_pre_d;
  logic [TIMER_BITS-1:0] act_pre_q, act_pre_d;
  logic [R-1:0]          pwm_cnt_q, pwm_cnt_d;
  logic                  pwm_q, pwm_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tick_s;
  logic                  period_end_s;

  timer #(
    .BITS(TIMER_BITS)
  ) u_prescaler (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (1'b1),
    .FINAL_VALUE(act_pre_q),
    .done       (tick_s)
  );

  // A period ends on the tick that wraps the period counter; the timer wraps on the same edge.
  assign period_end_s = tick_s && (pwm_cnt_q == CNT_MAX);

  // Period counter and registered waveform compare; prescale swaps only at a period boundary.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    if (tick_s) begin
      pwm_cnt_d = pwm_cnt_q + R_ONE;
    end else begin
      pwm_cnt_d = pwm_cnt_q;
    end
    pwm_d = (pwm_cnt_q < duty_q);
    if (period_end_s) begin
      act_pre_d = pend_pre_q;
    end else begin
      act_pre_d = act_pre_q;
    end
  end

  // FSM next-state: stop wins over completion and stepping in RAMP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RAMP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RAMP: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (duty_q == target_q) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_RAMP;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs, decoded from the next state so busy/done come straight from flops.
  always_comb begin
    busy_d = is_busy(state_d);
    done_d = (state_d == ST_FINISH);
  end

  // Ramp datapath: latch the request in IDLE, step duty on period boundaries in RAMP.
  always_comb begin
    duty_d     = duty_q;
    target_d   = target_q;
    hold_d     = hold_q;
    hold_cnt_d = hold_cnt_q;
    pend_pre_d = pend_pre_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          target_d   = target;
          hold_d     = hold;
          pend_pre_d = prescale;
          hold_cnt_d = {HOLD_BITS{1'b0}};
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end
      ST_RAMP: begin
        if (!stop && (duty_q != target_q) && period_end_s) begin
          if (hold_cnt_q == hold_q) begin
            hold_cnt_d = {HOLD_BITS{1'b0}};
            if (target_q > duty_q) begin
              duty_d = duty_q + R_ONE;
            end else begin
              duty_d = duty_q - R_ONE;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end
      ST_FINISH: begin
        hold_cnt_d = hold_cnt_q;
      end
      default: begin
        hold_cnt_d = hold_cnt_q;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, PWM and handshake output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_q     <= {R{1'b0}};
      target_q   <= {R{1'b0}};
      hold_q     <= {HOLD_BITS{1'b0}};
      hold_cnt_q <= {HOLD_BITS{1'b0}};
      pend_pre_q <= {TIMER_BITS{1'b0}};
      act_pre_q  <= {TIMER_BITS{1'b0}};
      pwm_cnt_q  <= {R{1'b0}};
      pwm_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      duty_q     <= duty_d;
      target_q   <= target_d;
      hold_q     <= hold_d;
      hold_cnt_q <= hold_cnt_d;
      pend_pre_q <= pend_pre_d;
      act_pre_q  <= act_pre_d;
      pwm_cnt_q  <= pwm_cnt_d;
      pwm_q      <= pwm_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign duty    = duty_q;
  assign pwm_out = pwm_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: doc/pwm_ramp_controller.md
# pwm_ramp_controller

Single-channel PWM generator with a hardware duty-cycle ramp sequencer. A `timer` prescaler instance produces the PWM tick, an R-bit period counter forms the waveform, and a small FSM steps the duty value toward a requested target by ±1 every (hold+1) PWM periods, with a start/busy/done handshake. It sits between the control logic (buttons, UART or CPU registers) and an LED or motor pin, and replaces direct duty writes where soft fades are needed.

## Interface
- R, 8: PWM resolution in bits; period = 2^R ticks.
- TIMER_BITS, 16: prescaler width, passed to `timer` as BITS.
- HOLD_BITS, 8: width of the hold (periods-per-step) field.
- clk  in  1  system clock.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- start  in  1  request pulse; accepted only in IDLE.
- stop  in  1  abort ramp; honoured in RAMP only.
- target  in  R  duty to ramp to; sampled on accepted start.
- hold  in  HOLD_BITS  steps occur every hold+1 PWM periods; sampled on accepted start.
- prescale  in  TIMER_BITS  tick every prescale+1 clocks; sampled on accepted start.
- duty  out  R  current applied duty.
- pwm_out  out  1  registered PWM waveform.
- busy  out  1  high in RAMP and FINISH.
- done  out  1  one-cycle pulse in FINISH.

## Operation
- Reset values: duty=0, pwm_out=0, busy=0, done=0; pwm_cnt=0, hold_cnt=0, active and pending prescale=0, FSM=IDLE.
- Prescaler: `timer` with enable=1 and FINAL_VALUE=active_prescale. tick = timer done.
- Period counter: pwm_cnt increments on tick and wraps 2^R-1→0. period_end = tick && pwm_cnt==2^R-1.
- pwm_out is registered every clock as (pwm_cnt < duty). duty=0 gives a constant low. duty=2^R-1 gives high for 2^R-1 of 2^R ticks.
- Prescale handoff: an accepted start writes pending_prescale. active_prescale loads pending only on period_end, which coincides with the timer wrapping to 0. This prevents a count overrun when the new value is below the timer's current count.
- FSM:
  - IDLE: on start, latch target_reg, hold_reg and pending_prescale, clear hold_cnt, go to RAMP. stop is ignored.
  - RAMP: if stop, go to IDLE (duty frozen, no done). Else if duty==target_reg, go to FINISH. Else on period_end: if hold_cnt==hold_reg, clear hold_cnt and step duty one toward target_reg; otherwise increment hold_cnt.
  - FINISH: done=1 for one cycle, then go to IDLE.
- duty changes only on period_end, so there are no mid-period glitches.
- Arithmetic: duty never overshoots. Because steps are ±1 and the equality check runs every cycle, duty never wraps. hold_cnt is HOLD_BITS wide and cannot exceed hold_reg.
- start while busy: ignored; latched values are unchanged.
- stop and a step on the same cycle: stop wins and duty is not updated.
- The PWM keeps running in IDLE at the frozen duty.
- Asynchronous reset mid-ramp: everything returns to reset values immediately.

## Timing
- Tick period is prescale+1 clocks. PWM period is 2^R·(active_prescale+1) clocks.
- Start handshake: start sampled at edge N gives busy=1 from N+1.
- If target equals current duty, done is high in cycle N+2 and busy drops at N+3.
- The first step lands on the (hold+1)-th period_end after start. The first interval can be short by up to one period because the period in progress counts.
- The final step is at edge M. FSM sees equality at M+1, done is high in cycle M+2, and busy=0 from M+3.
- pwm_out lags pwm_cnt and duty by one clock.
- stop sampled at edge S gives busy=0 from S+1.

## Structure
- Shared package: FSM state encoding (IDLE, RAMP, FINISH) and the default R, TIMER_BITS and HOLD_BITS constants.
- One sub-module: the existing `timer` prescaler, instantiated as u_prescaler with BITS=TIMER_BITS. All other logic is in this module.

## Test plan
All scenarios use R=4, TIMER_BITS=4, HOLD_BITS=4.
- Reset: with no start, duty=0, pwm_out=0, busy=0 and done=0 for 100 clocks. Asserting reset_n low mid-ramp clears all of these within the same cycle.
- Ramp up: prescale=0, hold=0, target=4 from duty=0. duty steps 1,2,3,4 at consecutive period_ends 16 clocks apart, then one done pulse. The next period shows pwm_out high for exactly 4 of 16 clocks.
- Ramp down: from duty=10, hold=2, target=7. duty steps 9, 8, 7 every 3 periods (48 clocks apart), then done, and duty holds at 7.
- No-op and re-start: target equals duty gives done 2 cycles after start and no duty change. A start pulse during RAMP is ignored, and the original target is still reached.
- Stop: stop asserted mid-ramp at duty=3. busy=0 next cycle, done never asserts, duty stays at 3, and PWM continues at 3/16.
- Prescale change: running with prescale=0 and timer count at 0, start with prescale=3. Period length stays 16 clocks until the next period_end, then becomes 64 clocks, with no overrun of the timer count.
